// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StFlush = 3'd2,
    StRun   = 3'd3,
    StErr   = 3'd4
  } state_e;

  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned ByteCntW     = $clog2(BytesPerWord);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into a word; presents the completed word combinationally.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      clear_i,
  input  logic                      accept_i,
  input  logic                      last_i,
  input  logic [7:0]                data_i,
  output logic                      word_valid_o,
  output logic [8*BytesPerWord-1:0] word_o
);

  logic [ByteCntW-1:0]       cnt_q, cnt_d;
  logic [8*BytesPerWord-1:0] buf_q, buf_d;

  assign word_valid_o = accept_i && (last_i || (cnt_q == ByteCntW'(BytesPerWord - 1)));

  // Merge the incoming byte so the word is complete in the same cycle it is accepted.
  always_comb begin
    word_o = buf_q;
    if (accept_i) begin
      word_o = buf_q | ({{(8*BytesPerWord-8){1'b0}}, data_i} << {cnt_q, 3'b000});
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clear_i || word_valid_o) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (accept_i) begin
      cnt_d = cnt_q + ByteCntW'(1);
      buf_d = word_o;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot sequencer: holds the core in reset, streams a byte image into instruction memory,
// then releases the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_reset_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam int unsigned Capacity = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LastIdx = (ADDR_W+1)'(Capacity - 1);
  localparam logic [ADDR_W:0] WcOne   = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wc_q, wc_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                core_reset_q, core_reset_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept, clear, word_valid;
  logic [31:0]         word;

  assign in_ready_o = (state_q == StLoad);
  assign accept     = in_valid_i && in_ready_o;

  imem_loader_byte_packer u_packer (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (clear),
    .accept_i     (accept),
    .last_i       (in_last_i),
    .data_i       (in_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle, StRun, StErr: begin
        if (start_i) begin
          state_d = StLoad;
          wc_d    = '0;
          clear   = 1'b1;
        end
      end
      StLoad: begin
        if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = wc_q[ADDR_W-1:0];
          wdata_d = word;
          wc_d    = wc_q + WcOne;
          if (in_last_i) begin
            state_d = StFlush;
          end else if (wc_q == LastIdx) begin
            state_d = StErr;
          end
        end
      end
      StFlush: state_d = StRun;
      default: state_d = StIdle;
    endcase
    // Status outputs are registered from the next state so they align with it.
    core_reset_d = (state_d != StRun);
    done_d       = (state_d == StRun);
    err_d        = (state_d == StErr);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      wc_q         <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wc_q         <= wc_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign core_reset_o = core_reset_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 64-word instance for normal loads and a 4-word one for overflow.
module tb_imem_loader;

  typedef struct packed {
    logic [63:0] bytes;  // byte i at [8i+:8]
    logic [3:0]  n;
    logic [63:0] words;  // word k at [32k+:32]
    logic [1:0]  nw;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start [2];
  logic       in_valid [2];
  logic       in_last [2];
  logic [7:0] in_data [2];

  logic        rdy_a, we_a, core_reset_a, done_a, err_a;
  logic [5:0]  addr_a;
  logic [31:0] wdata_a;
  logic [6:0]  wc_a;
  logic        rdy_b, we_b, core_reset_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  wc_b;

  int total = 0;
  int bad = 0;
  vec_t vecs [4];
  int          log_addr [$];
  logic [31:0] log_data [$];
  logic [7:0]  img [256];
  logic [31:0] err_words [4];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(6)) u_dut_a (
    .clk_i(clk), .reset_i(reset), .start_i(start[0]), .in_valid_i(in_valid[0]),
    .in_data_i(in_data[0]), .in_last_i(in_last[0]), .in_ready_o(rdy_a), .imem_we_o(we_a),
    .imem_addr_o(addr_a), .imem_wdata_o(wdata_a), .core_reset_o(core_reset_a),
    .done_o(done_a), .err_o(err_a), .word_count_o(wc_a)
  );

  imem_loader #(.ADDR_W(2)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .start_i(start[1]), .in_valid_i(in_valid[1]),
    .in_data_i(in_data[1]), .in_last_i(in_last[1]), .in_ready_o(rdy_b), .imem_we_o(we_b),
    .imem_addr_o(addr_b), .imem_wdata_o(wdata_b), .core_reset_o(core_reset_b),
    .done_o(done_b), .err_o(err_b), .word_count_o(wc_b)
  );

  always @(negedge clk) begin
    if (!reset && we_a === 1'b1) begin
      log_addr.push_back(int'(addr_a));
      log_data.push_back(wdata_a);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input int u);
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
  endtask

  // Presents one byte and returns 1 time unit after the edge that accepted it.
  task automatic send_byte(input int u, input logic [7:0] d, input logic l, input int gap);
    int n;
    logic ok;
    in_valid[u] = 1'b0;
    repeat (gap) tick();
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_last[u]  = l;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = (u == 0) ? rdy_a : rdy_b;
      tick();
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: dut %0d never ready for byte %0h", u, d);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = int'(v.n);
    start_pulse(0);
    chk("load_ready", rdy_a, 1);
    chk("load_core_reset", core_reset_a, 1);
    chk("load_done", done_a, 0);
    chk("load_wc", wc_a, 0);
    for (int i = 0; i < n; i++) begin
      send_byte(0, v.bytes[8*i +: 8], i == n - 1, 0);
      if (i % 4 == 3 || i == n - 1) begin
        chk("wr_we", we_a, 1);
        chk("wr_addr", addr_a, i / 4);
        chk("wr_data", wdata_a, v.words[32*(i/4) +: 32]);
      end else begin
        chk("no_we_mid_word", we_a, 0);
      end
    end
    in_valid[0] = 1'b0;
    in_last[0]  = 1'b0;
    chk("flush_ready", rdy_a, 0);
    chk("flush_core_reset", core_reset_a, 1);
    tick();
    chk("run_core_reset", core_reset_a, 0);
    chk("run_done", done_a, 1);
    chk("run_err", err_a, 0);
    chk("run_wc", wc_a, v.nw);
    in_valid[0] = 1'b1;
    repeat (3) begin
      tick();
      chk("run_ignore_we", we_a, 0);
    end
    in_valid[0] = 1'b0;
    chk("run_ignore_wc", wc_a, v.nw);
    chk("run_ignore_done", done_a, 1);
  endtask

  initial begin
    int n;
    vecs[0] = '{bytes: 64'h0010_0593_0000_0513, n: 4'd8, words: 64'h0010_0593_0000_0513, nw: 2'd2};
    vecs[1] = '{bytes: 64'h0000_2211_DDCC_BBAA, n: 4'd6, words: 64'h0000_2211_DDCC_BBAA, nw: 2'd2};
    vecs[2] = '{bytes: 64'h0000_0000_0000_005A, n: 4'd1, words: 64'h0000_0000_0000_005A, nw: 2'd1};
    vecs[3] = '{bytes: 64'h0000_0005_0403_0201, n: 4'd5, words: 64'h0000_0005_0403_0201, nw: 2'd2};
    err_words[0] = 32'h0302_0100;
    err_words[1] = 32'h0706_0504;
    err_words[2] = 32'h0B0A_0908;
    err_words[3] = 32'h0F0E_0D0C;

    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; in_valid[u] = 1'b0; in_last[u] = 1'b0; in_data[u] = 8'h00;
    end
    #12;
    chk("rst_core_reset", core_reset_a, 1);
    chk("rst_in_ready", rdy_a, 0);
    chk("rst_we", we_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_wdata", wdata_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_wc", wc_a, 0);
    tick();
    reset = 1'b0;

    // Idle with in_valid high must stay inert.
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_inert", {core_reset_a, rdy_a, we_a, core_reset_b, rdy_b, we_b}, 6'b100_100);
    end
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;

    for (int k = 0; k < 4; k++) run_vec(vecs[k]);

    // Overflow on the 4-word instance.
    start_pulse(1);
    for (int i = 0; i < 16; i++) begin
      send_byte(1, 8'(i), 1'b0, 0);
      if (i % 4 == 3) begin
        chk("ovf_we", we_b, 1);
        chk("ovf_addr", addr_b, i / 4);
        chk("ovf_data", wdata_b, err_words[i/4]);
      end
    end
    chk("ovf_err", err_b, 1);
    chk("ovf_core_reset", core_reset_b, 1);
    chk("ovf_ready", rdy_b, 0);
    chk("ovf_done", done_b, 0);
    chk("ovf_wc", wc_b, 4);
    in_data[1] = 8'h10;
    repeat (3) begin
      tick();
      chk("err_no_write", {we_b, rdy_b, err_b}, 3'b001);
    end
    in_valid[1] = 1'b0;
    start_pulse(1);
    chk("err_restart_err", err_b, 0);
    chk("err_restart_ready", rdy_b, 1);
    chk("err_restart_wc", wc_b, 0);

    // Full-capacity image with random gaps.
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    log_addr.delete();
    log_data.delete();
    start_pulse(0);
    for (int i = 0; i < 256; i++) send_byte(0, img[i], i == 255, int'($urandom_range(0, 3)));
    in_valid[0] = 1'b0;
    in_last[0]  = 1'b0;
    n = 0;
    while (!done_a && n < 20) begin
      tick();
      n++;
    end
    chk("rand_done", done_a, 1);
    chk("rand_wc", wc_a, 64);
    chk("rand_nwrites", log_addr.size(), 64);
    for (int k = 0; k < 64 && k < log_addr.size(); k++) begin
      chk("rand_addr", log_addr[k], k);
      chk("rand_data", log_data[k], {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]});
    end

    // Reset part-way through the second word.
    start_pulse(0);
    log_addr.delete();
    log_data.delete();
    for (int i = 0; i < 6; i++) send_byte(0, 8'(8'hC0 + i), 1'b0, 0);
    in_valid[0] = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_core_reset", core_reset_a, 1);
    chk("midrst_ready", rdy_a, 0);
    chk("midrst_we", we_a, 0);
    chk("midrst_wc", wc_a, 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("midrst_nwrites", log_addr.size(), 1);
    chk("midrst_idle_ready", rdy_a, 0);
    chk("midrst_idle_core_reset", core_reset_a, 1);
    run_vec(vecs[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
